// File: rtl/cfg_pkg.sv
// Shared constants for the tile configuration chain.
// Also used by the wishbonatron firmware models.
package cfg_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;
    localparam int CFG_WIDTH_DEFAULT = 64;

    // One MSB-first CRC-8 step for a single serial bit.
    function automatic logic [7:0] crc8_step(
        input logic [7:0] crc,
        input logic       b
    );
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/cfg_crc8_serial.sv
// Serial CRC-8 accumulator, one bit per enabled cycle.
// Ports: clk_i, rst_i (sync, active-high), en_i (absorb bit_i),
//        clr_i (restart from init; with en_i the bit seeds the
//        new frame), bit_i, crc_o (registered running CRC).
module cfg_crc8_serial
    import cfg_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic [7:0] seed;

    always_comb begin
        seed  = clr_i ? CRC8_INIT : crc_q;
        crc_d = crc_q;
        if (en_i) begin
            crc_d = crc8_step(seed, bit_i);
        end else if (clr_i) begin
            crc_d = CRC8_INIT;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= CRC8_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/cfg_tile_loader.sv
// One fabric tile's config loader: a serial shift chain with a
// CRC-checked, count-qualified commit into the active config.
// Ports: wb_clk_i, wb_rst_i (sync, active-high), shift_in,
//        shift_en, set_in (commit request, edge-detected),
//        shift_out (to next tile), cfg_out, cfg_valid,
//        set_err (1-cycle reject pulse), crc_out (CRC of last
//        accepted frame).
module cfg_tile_loader
    import cfg_pkg::*;
#(
    parameter int CFG_WIDTH = CFG_WIDTH_DEFAULT
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 shift_in,
    input  logic                 shift_en,
    input  logic                 set_in,
    output logic                 shift_out,
    output logic [CFG_WIDTH-1:0] cfg_out,
    output logic                 cfg_valid,
    output logic                 set_err,
    output logic [7:0]           crc_out
);

    localparam int CW = $clog2(CFG_WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(CFG_WIDTH);

    logic [CFG_WIDTH-1:0] sr_q, sr_d;
    logic [CFG_WIDTH-1:0] cfg_q, cfg_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [7:0]           crco_q, crco_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 set_q;
    logic                 set_rise;
    logic                 full;
    logic [7:0]           crc_run;

    assign set_rise = set_in & ~set_q;
    assign full     = (cnt_q == FULL);

    // A commit restarts the running CRC; a shift in the same
    // cycle becomes the first bit of the next frame.
    cfg_crc8_serial u_crc (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .en_i  (shift_en),
        .clr_i (set_rise),
        .bit_i (shift_in),
        .crc_o (crc_run)
    );

    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        crco_d  = crco_q;
        valid_d = valid_q;
        err_d   = 1'b0;

        if (shift_en) begin
            sr_d = {sr_q[CFG_WIDTH-2:0], shift_in};
        end

        if (set_rise) begin
            cnt_d = shift_en ? CW'(1) : '0;
        end else if (shift_en && !full) begin
            cnt_d = cnt_q + CW'(1);
        end

        // Commit uses pre-edge sr/count/crc.
        if (set_rise) begin
            if (full) begin
                cfg_d   = sr_q;
                crco_d  = crc_run;
                valid_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            cfg_q   <= '0;
            crco_q  <= CRC8_INIT;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            set_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            crco_q  <= crco_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            set_q   <= set_in;
        end
    end

    // sr MSB is a register bit; it only moves on shift_en.
    assign shift_out = sr_q[CFG_WIDTH-1];
    assign cfg_out   = cfg_q;
    assign cfg_valid = valid_q;
    assign set_err   = err_q;
    assign crc_out   = crco_q;

endmodule

// File: tb/tb_cfg_tile_loader.sv
// Self-checking bench for cfg_tile_loader at CFG_WIDTH=8.
// Table-driven frames plus hand sequences for corner cases.
module tb_cfg_tile_loader;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         shift_in;
    logic         shift_en;
    logic         set_in;
    logic         shift_out;
    logic [W-1:0] cfg_out;
    logic         cfg_valid;
    logic         set_err;
    logic [7:0]   crc_out;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [7:0] cfg;
        logic [7:0] crc;
        logic       valid;
        logic       err;
    } exp_t;

    typedef struct {
        logic [7:0] d;
        int         n;
        exp_t       e;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[5];

    cfg_tile_loader #(.CFG_WIDTH(W)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .shift_in  (shift_in),
        .shift_en  (shift_en),
        .set_in    (set_in),
        .shift_out (shift_out),
        .cfg_out   (cfg_out),
        .cfg_valid (cfg_valid),
        .set_err   (set_err),
        .crc_out   (crc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] crc8_ref(
        input logic [15:0] d,
        input int          n
    );
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = n - 1; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic exp_t mk_e(
        input logic [7:0] c,
        input logic [7:0] r,
        input logic       v,
        input logic       e
    );
        exp_t x;
        x.cfg   = c;
        x.crc   = r;
        x.valid = v;
        x.err   = e;
        return x;
    endfunction

    function automatic vec_t mk_v(
        input logic [7:0] d,
        input int         n,
        input exp_t       e
    );
        vec_t x;
        x.d = d;
        x.n = n;
        x.e = e;
        return x;
    endfunction

    task automatic check(
        input string       name,
        input logic [31:0] act,
        input logic [31:0] exp
    );
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic tick(
        input logic en,
        input logic b,
        input logic s
    );
        shift_en = en;
        shift_in = b;
        set_in   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(
        input logic [15:0] d,
        input int          n
    );
        for (int i = n - 1; i >= 0; i--) begin
            tick(1'b1, d[i], 1'b0);
        end
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            check({tag, "_cfg"}, 32'(cfg_out), 32'(e.cfg));
            check({tag, "_crc"}, 32'(crc_out), 32'(e.crc));
            check({tag, "_valid"}, 32'(cfg_valid), 32'(e.valid));
            check({tag, "_err"}, 32'(set_err), 32'(e.err));
        end
    endtask

    task automatic commit(
        input string tag,
        input logic  en,
        input logic  b,
        input exp_t  e
    );
        sbq.push_back(e);
        tick(en, b, 1'b1);
        pop_cmp(tag);
        tick(1'b0, 1'b0, 1'b0);
        check({tag, "_err_end"}, 32'(set_err), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_cfg"}, 32'(cfg_out), 32'd0);
        check({tag, "_crc"}, 32'(crc_out), 32'd0);
        check({tag, "_valid"}, 32'(cfg_valid), 32'd0);
        check({tag, "_err"}, 32'(set_err), 32'd0);
        check({tag, "_sout"}, 32'(shift_out), 32'd0);
    endtask

    initial begin
        logic [15:0] two;
        logic [7:0]  pat;

        rst      = 1'b1;
        shift_in = 1'b0;
        shift_en = 1'b0;
        set_in   = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk_zero("reset");
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0);

        vt[0] = mk_v(8'h1F, 5, mk_e(8'h00, 8'h00, 1'b0, 1'b1));
        vt[1] = mk_v(8'hA5, 8, mk_e(8'hA5, 8'h72, 1'b1, 1'b0));
        vt[2] = mk_v(8'h05, 3, mk_e(8'hA5, 8'h72, 1'b1, 1'b1));
        vt[3] = mk_v(8'hC3, 8,
                     mk_e(8'hC3, crc8_ref(16'h00C3, 8), 1'b1, 1'b0));
        vt[4] = mk_v(8'h00, 8, mk_e(8'h00, 8'h00, 1'b1, 1'b0));

        for (int i = 0; i < 5; i++) begin
            shift_bits({8'h00, vt[i].d}, vt[i].n);
            commit($sformatf("vec%0d", i), 1'b0, 1'b0, vt[i].e);
        end

        // Two frames back to back: first frame leaves via shift_out.
        two = 16'hA53C;
        pat = 8'hA5;
        for (int k = 1; k <= 16; k++) begin
            shift_en = 1'b1;
            shift_in = two[16-k];
            set_in   = 1'b0;
            #3;
            if (k >= 9) begin
                check($sformatf("sout_k%0d", k),
                      32'(shift_out), 32'(pat[16-k]));
            end
            @(posedge clk);
            #1;
        end
        commit("chain", 1'b0, 1'b0,
               mk_e(8'h3C, crc8_ref(16'hA53C, 16), 1'b1, 1'b0));

        // Commit and shift in the same cycle.
        shift_bits(16'h00FF, 8);
        commit("same_cyc", 1'b1, 1'b0,
               mk_e(8'hFF, crc8_ref(16'h00FF, 8), 1'b1, 1'b0));
        shift_bits(16'h0000, 7);
        commit("same_nxt", 1'b0, 1'b0,
               mk_e(8'h00, 8'h00, 1'b1, 1'b0));

        // Reset mid-frame, with shift/set asserted during reset.
        shift_bits(16'h000A, 4);
        rst = 1'b1;
        tick(1'b1, 1'b1, 1'b1);
        chk_zero("rst_mid");
        rst = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        shift_bits(16'h000F, 4);
        commit("rst_part", 1'b0, 1'b0,
               mk_e(8'h00, 8'h00, 1'b0, 1'b1));
        shift_bits(16'h005A, 8);
        commit("rst_fresh", 1'b0, 1'b0,
               mk_e(8'h5A, crc8_ref(16'h005A, 8), 1'b1, 1'b0));

        // set_in held high for three cycles.
        shift_bits(16'h0096, 8);
        sbq.push_back(mk_e(8'h96, crc8_ref(16'h0096, 8),
                           1'b1, 1'b0));
        tick(1'b0, 1'b0, 1'b1);
        pop_cmp("hold1");
        for (int j = 2; j <= 3; j++) begin
            tick(1'b0, 1'b0, 1'b1);
            check($sformatf("hold%0d_err", j), 32'(set_err), 32'd0);
            check($sformatf("hold%0d_cfg", j), 32'(cfg_out), 32'h96);
        end
        tick(1'b0, 1'b0, 1'b0);
        check("hold_end_err", 32'(set_err), 32'd0);
        check("hold_end_crc", 32'(crc_out),
              32'(crc8_ref(16'h0096, 8)));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cfg_tile_loader.md
CFG_TILE_LOADER -- requirements
Module: cfg_tile_loader

Interface
REQ-001 SHALL have parameter CFG_WIDTH, default 64: number of config bits held by one fabric tile (range 8..256).
REQ-002 SHALL have port wb_clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port wb_rst_i  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port shift_in  input  1  serial config bit from the upstream chain (wishbonatron shift_out or the previous tile).
REQ-005 SHALL have port shift_en  input  1  advance the chain one bit this cycle.
REQ-006 SHALL have port set_in  input  1  commit request; copies the shift register into the active config.
REQ-007 SHALL have port shift_out  output  1  serial bit to the downstream tile.
REQ-008 SHALL have port cfg_out  output  CFG_WIDTH  active tile configuration driven into the fabric.
REQ-009 SHALL have port cfg_valid  output  1  active config has been loaded at least once since reset.
REQ-010 SHALL have port set_err  output  1  one-cycle pulse: commit rejected.
REQ-011 SHALL have port crc_out  output  8  CRC-8 of the bits that formed the last accepted commit.

Function
REQ-012 SHALL, on shift_en, perform sr <= {sr[CFG_WIDTH-2:0], shift_in}; the first bit shifted ends as the MSB after CFG_WIDTH shifts.
REQ-013 SHALL drive shift_out = sr[CFG_WIDTH-1] (registered); chain latency is exactly CFG_WIDTH shift_en cycles; shift_out holds when shift_en is low.
REQ-014 SHALL keep bit_cnt, width clog2(CFG_WIDTH+1): +1 per shift_en, saturating at CFG_WIDTH, never wrapping.
REQ-015 SHALL update running CRC-8 (poly 0x07, init 0x00, MSB-first) on every shift_en: fb = crc[7]^shift_in; crc <= {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00).
REQ-016 SHALL, on set_in with bit_cnt == CFG_WIDTH: cfg_out <= sr, crc_out <= crc, cfg_valid <= 1; visible the next cycle.
REQ-017 SHALL, on set_in with bit_cnt < CFG_WIDTH: leave cfg_out, crc_out and cfg_valid unchanged and pulse set_err for exactly one cycle.
REQ-018 SHALL, after any set_in (accepted or rejected), restart bit_cnt and crc for the next frame.
REQ-019 SHALL, when set_in and shift_en occur in the same cycle: commit the pre-edge sr, bit_cnt and crc; perform the shift; then set bit_cnt <= 1 and crc <= CRC-8 step from 0x00 with shift_in.
REQ-020 SHALL hold cfg_valid at 1 once set; a later rejected commit does not clear it.
REQ-021 SHALL ignore set_in held high on consecutive cycles beyond the first (rising-edge detect); the second cycle produces no commit and no error.

Reset
REQ-022 SHALL, while wb_rst_i is high: sr=0, shift_out=0, bit_cnt=0, crc=0x00, cfg_out=0, crc_out=0x00, cfg_valid=0, set_err=0, set-edge detector cleared.
REQ-023 SHALL treat reset mid-frame as an abort: partial bits are discarded and the next frame starts from bit_cnt=0.
REQ-024 SHALL give reset priority over shift_en and set_in in the same cycle.

Structure
REQ-025 SHALL take CRC8_POLY (8'h07), CRC8_INIT (8'h00) and CFG_WIDTH_DEFAULT (64) from shared package cfg_pkg, used also by wishbonatron firmware models.
REQ-026 SHALL place the serial CRC step in one sub-module, cfg_crc8_serial (inputs: clk, rst, en, clr, bit; output: crc[7:0]).
REQ-027 SHALL contain no latches; all outputs are registered.

Verification (bench CFG_WIDTH=8)
REQ-028 SHALL cover: shift 8'hA5 MSB-first (8 shift_en cycles), then set_in -> cfg_out=8'hA5, crc_out=8'h72, cfg_valid=1, set_err=0.
REQ-029 SHALL cover: shift only 5 bits, then set_in -> set_err high for 1 cycle, cfg_out stays 8'h00, cfg_valid stays 0.
REQ-030 SHALL cover: shift 16 bits 0xA5 then 0x3C -> shift_out emits 1,0,1,0,0,1,0,1 on shift cycles 9..16; set_in then gives cfg_out=8'h3C.
REQ-031 SHALL cover: after 8 shifts of 0xFF, set_in with shift_en, shift_in=0 -> cfg_out=8'hFF, bit_cnt=1; 7 more zeros then set_in -> cfg_out=8'h00 accepted.
REQ-032 SHALL cover: wb_rst_i asserted after 4 of 8 bits -> all outputs zero next cycle; a fresh 8-bit frame then commits correctly.
REQ-033 SHALL cover: set_in held high for 3 cycles after a full frame -> exactly one commit and no set_err.
